djb2_axil_slave: RTL and testbench

//  AXI4-Lite responder holding a djb2 string-hash engine, hash = hash*33 + byte (mod 2^32).

---
 rtl/djb2_axil_slave.sv | 233 +++++++++++++++++++++++
 tb/tb_djb2_axil_slave.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/djb2_axil_slave.sv
// -----------------------------------------------------------------------------
// djb2_axil_slave
//   AXI4-Lite responder wrapping a djb2 string-hash engine:
//   hash = hash*33 + byte (mod 2^32).
//   Software seeds the hash through SEED, streams bytes through DATA writes
//   (one strobed byte lane hashed per clock, ascending lanes) and reads back
//   HASH and COUNT.
//
//   Register map (addr[3:2]):
//     0x0 SEED  RW  write also loads hash <= WDATA and clears COUNT
//     0x4 DATA  W   strobed bytes are fed to the engine; reads return 0
//     0x8 HASH  RO  live accumulator
//     0xC COUNT RO  bytes hashed since the last SEED write (wraps at 2^32)
//
// Ports
//   ACLK, ARESET        clock, asynchronous active-high reset
//   S_AXI_AW* / S_AXI_W* write address/data channels (AW and W taken together)
//   S_AXI_B*            write response, always OKAY
//   S_AXI_AR* / S_AXI_R* read address/data channels, always OKAY
//   busy                high while the engine is consuming bytes
//   hash_o              live accumulator value
// -----------------------------------------------------------------------------
module djb2_axil_slave #(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 4,
   parameter logic [31:0] SEED_RESET         = 32'd5381
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic                              busy,
   output logic [31:0]                       hash_o
);

   localparam int NB = C_S_AXI_DATA_WIDTH / 8;
   localparam int LW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [NB-1:0] ONE_LANE = NB'(1);

   localparam logic [1:0] REG_SEED  = 2'd0;
   localparam logic [1:0] REG_DATA  = 2'd1;
   localparam logic [1:0] REG_HASH  = 2'd2;
   localparam logic [1:0] REG_COUNT = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HASH = 2'd1,
      ST_RESP = 2'd2
   } wr_state_t;

   wr_state_t                   state_reg, state_next;
   logic [C_S_AXI_DATA_WIDTH-1:0] data_reg, data_next;
   logic [NB-1:0]               strb_reg, strb_next;
   logic [31:0]                 seed_reg, seed_next;
   logic [31:0]                 hash_reg, hash_next;
   logic [31:0]                 count_reg, count_next;
   logic                        rvalid_reg;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;

   logic                        wr_accept;
   logic                        bvalid_comb;
   logic                        busy_comb;
   logic [1:0]                  aw_sel;
   logic [1:0]                  ar_sel;

   assign aw_sel = S_AXI_AWADDR[3:2];
   assign ar_sel = S_AXI_ARADDR[3:2];

   // ---------------------------------------------------------------------
   // Byte lane selection: pick the lowest strobed lane still pending.
   // ---------------------------------------------------------------------
   logic [7:0]    lane_byte [NB];
   logic [LW-1:0] lane_sel;
   logic [NB-1:0] strb_rest;
   logic [7:0]    cur_byte;
   logic [31:0]   hash_mix;

   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign lane_byte[gi] = data_reg[gi*8 +: 8];
   end

   always_comb begin
      lane_sel = '0;
      for (int i = NB - 1; i >= 0; i--) begin
         if (strb_reg[i]) begin
            lane_sel = LW'(i);
         end
      end
   end

   // Clearing the lowest set bit leaves the lanes still to be hashed.
   assign strb_rest = strb_reg & (strb_reg - ONE_LANE);
   assign cur_byte  = lane_byte[lane_sel];
   assign hash_mix  = (hash_reg << 5) + hash_reg + {24'b0, cur_byte};

   // ---------------------------------------------------------------------
   // Write FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_reg <= ST_IDLE;
         data_reg  <= '0;
         strb_reg  <= '0;
         seed_reg  <= SEED_RESET;
         hash_reg  <= SEED_RESET;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
         strb_reg  <= strb_next;
         seed_reg  <= seed_next;
         hash_reg  <= hash_next;
         count_reg <= count_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      data_next   = data_reg;
      strb_next   = strb_reg;
      seed_next   = seed_reg;
      hash_next   = hash_reg;
      count_next  = count_reg;
      wr_accept   = 1'b0;
      bvalid_comb = 1'b0;
      busy_comb   = 1'b0;

      unique case (state_reg)
         ST_IDLE: begin
            // AW is only taken together with W, so one address never
            // waits around for its data.
            if (S_AXI_AWVALID && S_AXI_WVALID) begin
               wr_accept = 1'b1;
               data_next = S_AXI_WDATA;
               strb_next = S_AXI_WSTRB;
               if (aw_sel == REG_DATA && |S_AXI_WSTRB) begin
                  state_next = ST_HASH;
               end else begin
                  if (aw_sel == REG_SEED) begin
                     seed_next  = S_AXI_WDATA[31:0];
                     hash_next  = S_AXI_WDATA[31:0];
                     count_next = '0;
                  end
                  state_next = ST_RESP;
               end
            end
         end
         ST_HASH: begin
            busy_comb  = 1'b1;
            hash_next  = hash_mix;
            count_next = count_reg + 32'd1;
            strb_next  = strb_rest;
            if (strb_rest == '0) begin
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            bvalid_comb = 1'b1;
            if (S_AXI_BREADY) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign S_AXI_AWREADY = wr_accept;
   assign S_AXI_WREADY  = wr_accept;
   assign S_AXI_BVALID  = bvalid_comb;
   assign S_AXI_BRESP   = 2'b00;
   assign busy          = busy_comb;
   assign hash_o        = hash_reg;

   // ---------------------------------------------------------------------
   // Read channel, independent of the write FSM. The latch uses the
   // register values before this edge's update.
   // ---------------------------------------------------------------------
   logic [31:0] rd_mux;

   always_comb begin
      rd_mux = '0;
      unique case (ar_sel)
         REG_SEED:  rd_mux = seed_reg;
         REG_DATA:  rd_mux = '0;
         REG_HASH:  rd_mux = hash_reg;
         REG_COUNT: rd_mux = count_reg;
         default:   rd_mux = '0;
      endcase
   end

   assign S_AXI_ARREADY = S_AXI_ARVALID && !rvalid_reg;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rvalid_reg <= 1'b0;
         rdata_reg  <= '0;
      end else begin
         if (S_AXI_ARVALID && !rvalid_reg) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= C_S_AXI_DATA_WIDTH'(rd_mux);
         end else if (rvalid_reg && S_AXI_RREADY) begin
            rvalid_reg <= 1'b0;
         end
      end
   end

   assign S_AXI_RVALID = rvalid_reg;
   assign S_AXI_RDATA  = rdata_reg;
   assign S_AXI_RRESP  = 2'b00;

   // Protection bits and sub-word address bits carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                          data_reg};

endmodule

// File: tb/tb_djb2_axil_slave.sv
`timescale 1ns/1ps
module tb_djb2_axil_slave;

   logic        ACLK;
   logic        ARESET;
   logic [3:0]  S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [3:0]  S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic        busy;
   logic [31:0] hash_o;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   djb2_axil_slave dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .busy(busy), .hash_o(hash_o)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;
   always @(posedge ACLK) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Offer AW+W together; returns one step into cycle T+1 (T = accept cycle).
   task automatic start_write(input logic [3:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output int t);
      int n;
      S_AXI_AWADDR  = addr;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      #1;
      n = 0;
      while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 20) begin
         @(posedge ACLK); #1;
         n++;
      end
      checks++;
      if (!(S_AXI_AWREADY && S_AXI_WREADY)) begin
         errors++;
         $display("FAIL write_accept addr=%h: awready=%b wready=%b, required 1/1", addr,
                  S_AXI_AWREADY, S_AXI_WREADY);
      end
      t = cyc;
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
   endtask

   task automatic wait_b(output int bc);
      int n;
      n = 0;
      while (!S_AXI_BVALID && n < 30) begin
         @(posedge ACLK); #1;
         n++;
      end
      checks++;
      if (!S_AXI_BVALID || S_AXI_BRESP !== 2'b00) begin
         errors++;
         $display("FAIL bresp: bvalid=%b bresp=%b, required 1/00", S_AXI_BVALID, S_AXI_BRESP);
      end
      bc = cyc;
   endtask

   task automatic b_handshake();
      S_AXI_BREADY = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_BREADY = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output int lat);
      int t, bc;
      start_write(addr, data, strb, t);
      wait_b(bc);
      lat = bc - t;
      b_handshake();
      $display("write addr=%h data=%h strb=%h latency=%0d", addr, data, strb, lat);
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] d);
      int n;
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1'b1;
      #1;
      n = 0;
      while (!S_AXI_ARREADY && n < 20) begin
         @(posedge ACLK); #1;
         n++;
      end
      @(posedge ACLK); #1;
      S_AXI_ARVALID = 1'b0;
      checks++;
      if (!S_AXI_RVALID || S_AXI_RRESP !== 2'b00) begin
         errors++;
         $display("FAIL read_handshake addr=%h: rvalid=%b rresp=%b, required 1/00", addr,
                  S_AXI_RVALID, S_AXI_RRESP);
      end
      d = S_AXI_RDATA;
      S_AXI_RREADY = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_RREADY = 1'b0;
      $display("read  addr=%h data=%h", addr, d);
   endtask

   task automatic check_read(input string name, input logic [3:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      axi_read(addr, d);
      checks++;
      if (d !== exp) begin
         errors++;
         $display("FAIL %s: read %h, required %h", name, d, exp);
      end
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      repeat (3) @(posedge ACLK);
      #1;
      checks++;
      if (S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0 || S_AXI_AWREADY !== 1'b0 ||
          S_AXI_ARREADY !== 1'b0 || busy !== 1'b0 || S_AXI_RDATA !== 32'h0 ||
          hash_o !== 32'h00001505) begin
         errors++;
         $display("FAIL reset_outputs: bv=%b rv=%b awr=%b arr=%b busy=%b rdata=%h hash=%h, required 0 0 0 0 0 0 00001505",
                  S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_ARREADY, busy, S_AXI_RDATA, hash_o);
      end
      ARESET = 1'b0;
      @(posedge ACLK); #1;
      check_read("reset_seed", 4'h0, 32'h00001505);
      check_read("reset_hash", 4'h8, 32'h00001505);
      check_read("reset_count", 4'hC, 32'h00000000);
      check_read("data_reads_zero", 4'h4, 32'h00000000);
   endtask

   task automatic test_abc();
      int lat;
      do_write(4'h4, 32'h00636261, 4'h7, lat);
      checks++;
      if (lat != 4) begin
         errors++;
         $display("FAIL abc_latency: %0d, required 4", lat);
      end
      check_read("abc_hash", 4'h8, 32'h0B885C8B);
      check_read("abc_count", 4'hC, 32'd3);
      checks++;
      if (hash_o !== 32'h0B885C8B) begin
         errors++;
         $display("FAIL abc_hash_o: %h, required 0B885C8B", hash_o);
      end
   endtask

   task automatic test_seed_single();
      int lat;
      do_write(4'h0, 32'h00000000, 4'hF, lat);
      checks++;
      if (lat != 1) begin
         errors++;
         $display("FAIL seed_latency: %0d, required 1", lat);
      end
      do_write(4'h4, 32'h00000041, 4'h1, lat);
      checks++;
      if (lat != 2) begin
         errors++;
         $display("FAIL single_byte_latency: %0d, required 2", lat);
      end
      check_read("single_hash", 4'h8, 32'h00000041);
      check_read("single_count", 4'hC, 32'd1);
      do_write(4'h4, 32'h12345678, 4'h0, lat);
      checks++;
      if (lat != 1) begin
         errors++;
         $display("FAIL nostrobe_latency: %0d, required 1", lat);
      end
      check_read("nostrobe_hash", 4'h8, 32'h00000041);
      do_write(4'h8, 32'hDEADBEEF, 4'hF, lat);
      check_read("ro_write_hash", 4'h8, 32'h00000041);
      check_read("seed_readback", 4'h0, 32'h00000000);
      // Sparse strobes: lanes 1 and 3 only -> bytes 0x22 then 0x44 from seed 0.
      do_write(4'h4, 32'h44332211, 4'hA, lat);
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL sparse_latency: %0d, required 3", lat);
      end
      // ((0x41*33)+0x22)*33+0x44 = (2145+34)*33+68 = 71975 = 0x11927
      check_read("sparse_hash", 4'h8, 32'h00011927);
      check_read("sparse_count", 4'hC, 32'd3);
   endtask

   task automatic test_back_to_back();
      int t, bc, lat;
      do_write(4'h0, 32'h00001505, 4'hF, lat);
      start_write(4'h4, 32'h00636261, 4'h7, t);
      wait_b(bc);
      checks++;
      if (bc - t != 4) begin
         errors++;
         $display("FAIL hold_b_latency: %0d, required 4", bc - t);
      end
      S_AXI_AWADDR  = 4'h4;
      S_AXI_WDATA   = 32'h0;
      S_AXI_WSTRB   = 4'h0;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      #1;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (S_AXI_WREADY !== 1'b0 || S_AXI_AWREADY !== 1'b0 || S_AXI_BVALID !== 1'b1) begin
            errors++;
            $display("FAIL hold_b_cycle%0d: wready=%b awready=%b bvalid=%b, required 0 0 1",
                     i, S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID);
         end
         @(posedge ACLK); #1;
      end
      S_AXI_BREADY = 1'b1;
      #1;
      checks++;
      if (S_AXI_WREADY !== 1'b0) begin
         errors++;
         $display("FAIL wready_at_bhandshake: %b, required 0", S_AXI_WREADY);
      end
      @(posedge ACLK); #1;
      S_AXI_BREADY = 1'b0;
      checks++;
      if (S_AXI_BVALID !== 1'b0 || S_AXI_WREADY !== 1'b1 || S_AXI_AWREADY !== 1'b1) begin
         errors++;
         $display("FAIL accept_after_b: bvalid=%b wready=%b awready=%b, required 0 1 1",
                  S_AXI_BVALID, S_AXI_WREADY, S_AXI_AWREADY);
      end
      t = cyc;
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      wait_b(bc);
      checks++;
      if (bc - t != 1) begin
         errors++;
         $display("FAIL second_write_latency: %0d, required 1", bc - t);
      end
      b_handshake();
      $display("back_to_back second write latency=%0d", bc - t);
      check_read("b2b_hash", 4'h8, 32'h0B885C8B);
   endtask

   task automatic test_hash_poll();
      int t, bc, lat;
      logic [31:0] d;
      do_write(4'h0, 32'h00001505, 4'hF, lat);
      start_write(4'h4, 32'h00636261, 4'h7, t);
      checks++;
      if (busy !== 1'b1 || hash_o !== 32'h00001505) begin
         errors++;
         $display("FAIL poll_first_cycle: busy=%b hash=%h, required 1 00001505", busy, hash_o);
      end
      @(posedge ACLK); #1;
      checks++;
      if (hash_o !== 32'h0002B606) begin
         errors++;
         $display("FAIL poll_hash_o_byte1: %h, required 0002B606", hash_o);
      end
      // Latched at the end of T+2, before byte 2 lands.
      axi_read(4'h8, d);
      checks++;
      if (d !== 32'h0002B606) begin
         errors++;
         $display("FAIL poll_hash_read: %h, required 0002B606", d);
      end
      wait_b(bc);
      checks++;
      if (bc - t != 4) begin
         errors++;
         $display("FAIL poll_b_latency: %0d, required 4", bc - t);
      end
      b_handshake();

      do_write(4'h0, 32'h00001505, 4'hF, lat);
      start_write(4'h4, 32'h00636261, 4'h7, t);
      @(posedge ACLK); #1;
      @(posedge ACLK); #1;
      axi_read(4'hC, d);
      checks++;
      if (d !== 32'd2) begin
         errors++;
         $display("FAIL poll_count_read: %h, required 00000002", d);
      end
      wait_b(bc);
      b_handshake();
      check_read("poll_final_hash", 4'h8, 32'h0B885C8B);
   endtask

   task automatic test_reset_mid();
      int t, lat;
      do_write(4'h0, 32'h12345678, 4'hF, lat);
      start_write(4'h4, 32'h44434241, 4'hF, t);
      @(posedge ACLK); #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_mid_hash: %b, required 1", busy);
      end
      ARESET = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || hash_o !== 32'h00001505 || S_AXI_BVALID !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_hash: busy=%b hash=%h bvalid=%b, required 0 00001505 0",
                  busy, hash_o, S_AXI_BVALID);
      end
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      @(posedge ACLK); #1;
      check_read("post_reset_seed", 4'h0, 32'h00001505);
      check_read("post_reset_count", 4'hC, 32'd0);
      // Pending read response dropped by reset.
      S_AXI_ARADDR  = 4'h8;
      S_AXI_ARVALID = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_ARVALID = 1'b0;
      checks++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h00001505) begin
         errors++;
         $display("FAIL pending_read: rvalid=%b rdata=%h, required 1 00001505", S_AXI_RVALID, S_AXI_RDATA);
      end
      ARESET = 1'b1;
      #1;
      checks++;
      if (S_AXI_RVALID !== 1'b0 || S_AXI_RDATA !== 32'h0) begin
         errors++;
         $display("FAIL reset_drops_rvalid: rvalid=%b rdata=%h, required 0 00000000", S_AXI_RVALID, S_AXI_RDATA);
      end
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      @(posedge ACLK); #1;
   endtask

   task automatic test_wrap();
      int lat;
      do_write(4'h0, 32'hFFFFFFFF, 4'hF, lat);
      do_write(4'h4, 32'h000000FF, 4'h1, lat);
      check_read("wrap_hash", 4'h8, 32'h000000DE);
      check_read("wrap_count", 4'hC, 32'd1);
   endtask

   initial begin
      ARESET        = 1'b1;
      S_AXI_AWADDR  = '0;
      S_AXI_AWPROT  = '0;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA   = '0;
      S_AXI_WSTRB   = '0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_BREADY  = 1'b0;
      S_AXI_ARADDR  = '0;
      S_AXI_ARPROT  = '0;
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b0;
      @(posedge ACLK); #1;
      test_reset();
      test_abc();
      test_seed_single();
      test_back_to_back();
      test_hash_poll();
      test_reset_mid();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
